// File: rtl/test_status_monitor.sv
// End-of-test monitor: signature detection on NUM_CH store ports, run-cycle count, dump requests, timeout.
// Optional feature macro TSM_ADDR_FILTER_EN: signature stores must also target TOHOST_ADDR.
module test_status_monitor #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_CH         = 2,
  parameter logic [DATA_WIDTH-1:0] PASS_SIG    = DATA_WIDTH'(32'hdeadbeef),
  parameter logic [DATA_WIDTH-1:0] FAIL_SIG    = DATA_WIDTH'(32'hbadc0de0),
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = ADDR_WIDTH'(32'h0000_0ffc),
  parameter int unsigned DRAIN_CYCLES   = 5,
  parameter int unsigned DUMP_INTERVAL  = 100,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 32,
  localparam int unsigned HIT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NUM_CH-1:0]            st_valid,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] st_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] st_data,
  output logic                         dump_req,
  output logic                         done,
  output logic [1:0]                   status,
  output logic [HIT_W-1:0]             hit_ch,
  output logic [CNT_W-1:0]             cycle_count
);

  localparam int unsigned IV_W    = (DUMP_INTERVAL > 1) ? $clog2(DUMP_INTERVAL) : 1;
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam bit          DUMP_EN = (DUMP_INTERVAL != 0);

  localparam logic [1:0] ST_PASS    = 2'b01;
  localparam logic [1:0] ST_FAIL    = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  if (NUM_CH < 1 || DRAIN_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("test_status_monitor: need NUM_CH>=1, DRAIN_CYCLES>=1, TIMEOUT_CYCLES>=2");
  end
  if (CNT_W < 32 && (64'(TIMEOUT_CYCLES) - 64'd1) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
    $error("test_status_monitor: TIMEOUT_CYCLES-1 does not fit in CNT_W bits");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IV_W-1:0]    iv_q, iv_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [1:0]         status_q, status_d;
  logic [HIT_W-1:0]   hit_q, hit_d;
  logic               done_q, done_d;
  logic               dump_q, dump_d;

  logic [NUM_CH-1:0]  addr_ok;
  logic               fail_hit, pass_hit;
  logic [HIT_W-1:0]   fail_idx, pass_idx;

`ifdef TSM_ADDR_FILTER_EN
  for (genvar g = 0; g < NUM_CH; g++) begin : g_filt
    assign addr_ok[g] = (st_addr[g*ADDR_WIDTH +: ADDR_WIDTH] == TOHOST_ADDR);
  end
`else
  logic unused_addr;
  assign addr_ok     = '1;
  assign unused_addr = ^{st_addr, TOHOST_ADDR};
`endif

  // Lowest-index pass and fail matches; descending scan so the lowest index is written last
  always_comb begin
    fail_hit = 1'b0;
    pass_hit = 1'b0;
    fail_idx = '0;
    pass_idx = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (st_valid[i] && addr_ok[i]) begin
        if (st_data[i*DATA_WIDTH +: DATA_WIDTH] == FAIL_SIG) begin
          fail_hit = 1'b1;
          fail_idx = HIT_W'(i);
        end
        if (st_data[i*DATA_WIDTH +: DATA_WIDTH] == PASS_SIG) begin
          pass_hit = 1'b1;
          pass_idx = HIT_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    iv_d     = iv_q;
    drain_d  = drain_q;
    status_d = status_q;
    hit_d    = hit_q;
    done_d   = done_q;
    dump_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        // Drain counter holds DRAIN_CYCLES-1 so done rises DRAIN_CYCLES edges after termination
        if (fail_hit) begin
          status_d = ST_FAIL;
          hit_d    = fail_idx;
          drain_d  = DRAIN_W'(DRAIN_CYCLES - 1);
          state_d  = DRAIN;
        end else if (pass_hit) begin
          status_d = ST_PASS;
          hit_d    = pass_idx;
          drain_d  = DRAIN_W'(DRAIN_CYCLES - 1);
          state_d  = DRAIN;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          status_d = ST_TIMEOUT;
          hit_d    = '0;
          drain_d  = DRAIN_W'(DRAIN_CYCLES - 1);
          state_d  = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (DUMP_EN) begin
            if (iv_q == IV_W'(DUMP_INTERVAL - 1)) begin
              iv_d   = '0;
              dump_d = 1'b1;
            end else begin
              iv_d = iv_q + IV_W'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          dump_d  = 1'b1;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      iv_q     <= '0;
      drain_q  <= '0;
      status_q <= '0;
      hit_q    <= '0;
      done_q   <= 1'b0;
      dump_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      iv_q     <= iv_d;
      drain_q  <= drain_d;
      status_q <= status_d;
      hit_q    <= hit_d;
      done_q   <= done_d;
      dump_q   <= dump_d;
    end
  end

  assign dump_req    = dump_q;
  assign done        = done_q;
  assign status      = status_q;
  assign hit_ch      = hit_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_test_status_monitor.sv
// Bench for test_status_monitor: two instances (default, and short timeout/interval) checked against an edge-count model.
module tb_test_status_monitor;

  localparam int NCH   = 2;
  localparam int DRAIN = 5;
  localparam int TO_A  = 100000;
  localparam int DI_A  = 100;
  localparam int TO_B  = 50;
  localparam int DI_B  = 7;
  localparam logic [31:0] PASS   = 32'hdeadbeef;
  localparam logic [31:0] FAIL   = 32'hbadc0de0;
  localparam logic [31:0] TOHOST = 32'h0000_0ffc;
  localparam logic [31:0] OTHER  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  st_valid;
  logic [63:0] st_addr;
  logic [63:0] st_data;

  logic        dump_o   [2];
  logic        done_o   [2];
  logic [1:0]  status_o [2];
  logic [0:0]  hit_o    [2];
  logic [31:0] cnt_o    [2];

  test_status_monitor #(.DRAIN_CYCLES(DRAIN), .DUMP_INTERVAL(DI_A), .TIMEOUT_CYCLES(TO_A)) dut_a (
    .clk(clk), .rst(rst), .start(start), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .dump_req(dump_o[0]), .done(done_o[0]), .status(status_o[0]), .hit_ch(hit_o[0]),
    .cycle_count(cnt_o[0]));

  test_status_monitor #(.DRAIN_CYCLES(DRAIN), .DUMP_INTERVAL(DI_B), .TIMEOUT_CYCLES(TO_B)) dut_b (
    .clk(clk), .rst(rst), .start(start), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .dump_req(dump_o[1]), .done(done_o[1]), .status(status_o[1]), .hit_ch(hit_o[1]),
    .cycle_count(cnt_o[1]));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int edge_no  = 0;

  // Model: phase flags, counts and the edge number at which the test terminated
  bit m_started [2];
  bit m_term    [2];
  bit m_pdump   [2];
  int m_count   [2];
  int m_status  [2];
  int m_hit     [2];
  int m_tedge   [2];

  typedef struct {
    int          wait_cyc;
    logic [1:0]  v;
    logic [31:0] a0, d0, a1, d1;
    int          exp_status;
    int          exp_hit;
    int          exp_count;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_match(input logic [31:0] a);
`ifdef TSM_ADDR_FILTER_EN
    return a == TOHOST;
`else
    return a == a;
`endif
  endfunction

  task automatic model_reset(input int m);
    m_started[m] = 0; m_term[m] = 0; m_pdump[m] = 0;
    m_count[m] = 0; m_status[m] = 0; m_hit[m] = 0; m_tedge[m] = 0;
  endtask

  task automatic terminate(input int m, input int st, input int h);
    m_term[m]   = 1;
    m_status[m] = st;
    m_hit[m]    = h;
    m_tedge[m]  = edge_no + 1;
  endtask

  // Applies the current inputs to the model for the coming edge
  task automatic model_update(input int m);
    int f, p, lim, di;
    lim = (m == 0) ? TO_A : TO_B;
    di  = (m == 0) ? DI_A : DI_B;
    m_pdump[m] = 0;
    if (rst) begin
      model_reset(m);
      return;
    end
    if (!m_started[m]) begin
      if (start) m_started[m] = 1;
      return;
    end
    if (m_term[m]) return;
    f = -1;
    p = -1;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (st_valid[i] && addr_match(st_addr[i*32 +: 32])) begin
        if (st_data[i*32 +: 32] == FAIL) f = i;
        if (st_data[i*32 +: 32] == PASS) p = i;
      end
    end
    if (f >= 0)                    terminate(m, 2, f);
    else if (p >= 0)               terminate(m, 1, p);
    else if (m_count[m] == lim-1)  terminate(m, 3, 0);
    else begin
      m_count[m]++;
      m_pdump[m] = (di != 0) && (m_count[m] % di == 0);
    end
  endtask

  task automatic check_model();
    bit exp_done, exp_dump;
    for (int m = 0; m < 2; m++) begin
      exp_done = m_term[m] && (edge_no >= m_tedge[m] + DRAIN);
      exp_dump = m_pdump[m] || (m_term[m] && edge_no == m_tedge[m] + DRAIN);
      chk($sformatf("model_status[%0d]", m), status_o[m], m_status[m]);
      chk($sformatf("model_hit[%0d]", m), hit_o[m], m_hit[m]);
      chk($sformatf("model_count[%0d]", m), cnt_o[m], m_count[m]);
      chk($sformatf("model_done[%0d]", m), done_o[m], exp_done);
      chk($sformatf("model_dump[%0d]", m), dump_o[m], exp_dump);
    end
  endtask

  task automatic step();
    model_update(0);
    model_update(1);
    @(posedge clk);
    edge_no++;
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    st_valid = '0;
    st_addr  = '0;
    st_data  = '0;
  endtask

  task automatic do_reset();
    rst = 1; start = 0; idle_inputs();
    step();
    rst = 0;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    do_reset();
    start = 1; step(); start = 0;
    repeat (v.wait_cyc) step();
    st_valid = v.v;
    st_addr  = {v.a1, v.a0};
    st_data  = {v.d1, v.d0};
    step();
    idle_inputs();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("vec%0d_status[%0d]", n, m), status_o[m], v.exp_status);
      chk($sformatf("vec%0d_hit[%0d]", n, m), hit_o[m], v.exp_hit);
      chk($sformatf("vec%0d_count[%0d]", n, m), cnt_o[m], v.exp_count);
    end
    repeat (DRAIN - 1) step();
    chk($sformatf("vec%0d_done_early", n), done_o[0], 0);
    step();
    chk($sformatf("vec%0d_done", n), done_o[0], 1);
    chk($sformatf("vec%0d_final_dump", n), dump_o[0], 1);
    step();
    chk($sformatf("vec%0d_dump_pulse", n), dump_o[0], 0);
    chk($sformatf("vec%0d_done_sticky", n), done_o[0], 1);
  endtask

  initial begin
    int filt_hit, filt_st7, filt_hit7;
    int dumps[$];
    int prob;
    rst = 1; start = 0; idle_inputs();
    model_reset(0); model_reset(1);

`ifdef TSM_ADDR_FILTER_EN
    filt_hit = 1; filt_st7 = 1; filt_hit7 = 1;
`else
    filt_hit = 0; filt_st7 = 2; filt_hit7 = 0;
`endif
    vecs[0] = '{37, 2'b01, TOHOST, PASS, TOHOST, 32'h0, 1, 0, 37};
    vecs[1] = '{10, 2'b11, TOHOST, PASS, TOHOST, FAIL, 2, 1, 10};
    vecs[2] = '{5,  2'b10, TOHOST, 32'h1, TOHOST, PASS, 1, 1, 5};
    vecs[3] = '{0,  2'b11, TOHOST, FAIL, TOHOST, FAIL, 2, 0, 0};
    vecs[4] = '{20, 2'b11, TOHOST, FAIL, TOHOST, PASS, 2, 0, 20};
    vecs[5] = '{3,  2'b11, OTHER,  PASS, TOHOST, PASS, 1, filt_hit, 3};
    vecs[6] = '{8,  2'b11, OTHER,  FAIL, TOHOST, PASS, filt_st7, filt_hit7, 8};

    // Reset state
    step(); step();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("reset_status[%0d]", m), status_o[m], 0);
      chk($sformatf("reset_done[%0d]", m), done_o[m], 0);
      chk($sformatf("reset_count[%0d]", m), cnt_o[m], 0);
    end
    rst = 0;

    // Stores in IDLE are ignored
    st_valid = 2'b11; st_addr = {TOHOST, TOHOST}; st_data = {FAIL, PASS};
    repeat (3) step();
    idle_inputs();
    chk("idle_ignore_status", status_o[0], 0);

    for (int n = 0; n < 7; n++) run_vec(n, vecs[n]);

    // Periodic dumps on the default instance; short instance times out meanwhile
    do_reset();
    start = 1; step(); start = 0;
    for (int c = 0; c < 250; c++) begin
      step();
      if (dump_o[0]) dumps.push_back(int'(cnt_o[0]));
    end
    chk("periodic_pulses", dumps.size(), 2);
    if (dumps.size() == 2) begin
      chk("periodic_first", dumps[0], 100);
      chk("periodic_second", dumps[1], 200);
    end
    chk("timeout_status", status_o[1], 3);
    chk("timeout_count", cnt_o[1], 49);
    chk("timeout_hit", hit_o[1], 0);
    chk("timeout_done", done_o[1], 1);

    // Pass on the final run cycle beats timeout
    do_reset();
    start = 1; step(); start = 0;
    repeat (49) step();
    st_valid = 2'b01; st_addr = {32'h0, TOHOST}; st_data = {32'h0, PASS};
    step();
    idle_inputs();
    chk("last_cycle_pass_status", status_o[1], 1);
    chk("last_cycle_pass_count", cnt_o[1], 49);
    repeat (DRAIN) step();
    chk("last_cycle_pass_done", done_o[1], 1);

    // Asynchronous reset two cycles into DRAIN, then restart from zero
    do_reset();
    start = 1; step(); start = 0;
    repeat (3) step();
    st_valid = 2'b01; st_addr = {32'h0, TOHOST}; st_data = {32'h0, PASS};
    step();
    idle_inputs();
    step(); step();
    #2 rst = 1;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("async_rst_status[%0d]", m), status_o[m], 0);
      chk($sformatf("async_rst_count[%0d]", m), cnt_o[m], 0);
      chk($sformatf("async_rst_done[%0d]", m), done_o[m], 0);
      chk($sformatf("async_rst_dump[%0d]", m), dump_o[m], 0);
      model_reset(m);
    end
    step();
    rst = 0;
    start = 1; step(); start = 0;
    chk("restart_count0", cnt_o[0], 0);
    step();
    chk("restart_count1", cnt_o[0], 1);

    // Randomized episodes, including stray start pulses and stores outside RUN
    for (int ep = 0; ep < 30; ep++) begin
      prob = $urandom_range(3, 60);
      do_reset();
      repeat ($urandom_range(0, 3)) begin
        st_valid = 2'($urandom);
        st_data  = {PASS, FAIL};
        st_addr  = {TOHOST, TOHOST};
        step();
      end
      start = 1; step();
      for (int c = 0; c < 70; c++) begin
        start = ($urandom_range(0, 9) == 0);
        for (int i = 0; i < NCH; i++) begin
          int r;
          st_valid[i] = ($urandom_range(0, prob) == 0);
          r = $urandom_range(0, 3);
          st_data[i*32 +: 32] = (r == 0) ? PASS : (r == 1) ? FAIL : 32'($urandom);
          r = $urandom_range(0, 3);
          st_addr[i*32 +: 32] = (r < 2) ? TOHOST : (r == 2) ? OTHER : 32'($urandom);
        end
        step();
      end
      start = 0;
      idle_inputs();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
